rom_ram_copy_ctrl: RTL and testbench

ROM_RAM_COPY_CTRL -- requirements
Module: rom_ram_copy_ctrl

---
 rtl/rom_ram_copy_ctrl.sv | 134 +++++++++++++
 tb/tb_rom_ram_copy_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_ram_copy_ctrl.sv
// Copies a block of ROM words into RAM one word per two cycles, optionally
// reading the block back and counting words where RAM disagrees with ROM.
module rom_ram_copy_ctrl #(
   parameter int unsigned DATA_WIDTH = 3,
   parameter int unsigned M          = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic                verify_en,
   input  logic [M:0]          base_addr,
   input  logic [M:0]          length,
   input  logic [DATA_WIDTH:0] rom_data,
   input  logic [DATA_WIDTH:0] ram_q,
   output logic [M:0]          addr,
   output logic                we,
   output logic                busy,
   output logic                done,
   output logic [7:0]          mismatch_cnt,
   output logic                aborted
);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWr,
      StVrd,
      StVcmp,
      StDone
   } state_e;

   localparam logic [M:0] AddrOne = (M + 1)'(1);

   state_e     state_q, state_d;
   logic [M:0] addr_q, addr_d;
   logic [M:0] cnt_q, cnt_d;
   logic [M:0] base_q, base_d;
   logic [M:0] len_q, len_d;
   logic       verify_q, verify_d;
   logic [7:0] mismatch_q, mismatch_d;
   logic       aborted_q, aborted_d;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      len_d      = len_q;
      verify_d   = verify_q;
      mismatch_d = mismatch_q;
      aborted_d  = aborted_q;

      case (state_q)
         StIdle: begin
            if (start && !abort) begin
               base_d     = base_addr;
               len_d      = length;
               verify_d   = verify_en;
               mismatch_d = 8'd0;
               aborted_d  = 1'b0;
               cnt_d      = length;
               addr_d     = base_addr;
               state_d    = (length == '0) ? StDone : StRd;
            end
         end
         StRd: state_d = StWr;
         StWr: begin
            cnt_d  = cnt_q - AddrOne;
            addr_d = addr_q + AddrOne;
            if (cnt_q != AddrOne) begin
               state_d = StRd;
            end else if (verify_q) begin
               // Verify pass re-walks the same block from the start.
               addr_d  = base_q;
               cnt_d   = len_q;
               state_d = StVrd;
            end else begin
               state_d = StDone;
            end
         end
         StVrd: state_d = StVcmp;
         StVcmp: begin
            if ((rom_data != ram_q) && (mismatch_q != 8'hFF)) begin
               mismatch_d = mismatch_q + 8'd1;
            end
            cnt_d   = cnt_q - AddrOne;
            addr_d  = addr_q + AddrOne;
            state_d = (cnt_q != AddrOne) ? StVrd : StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Abort overrides whatever the active state decided this cycle.
      if ((state_q != StIdle) && abort) begin
         state_d    = StIdle;
         addr_d     = addr_q;
         cnt_d      = cnt_q;
         mismatch_d = mismatch_q;
         aborted_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         cnt_q      <= '0;
         base_q     <= '0;
         len_q      <= '0;
         verify_q   <= 1'b0;
         mismatch_q <= 8'd0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         len_q      <= len_d;
         verify_q   <= verify_d;
         mismatch_q <= mismatch_d;
         aborted_q  <= aborted_d;
      end
   end

   assign addr         = addr_q;
   assign we           = (state_q == StWr);
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign mismatch_cnt = mismatch_q;
   assign aborted      = aborted_q;

endmodule

// File: tb/tb_rom_ram_copy_ctrl.sv
// Bench for rom_ram_copy_ctrl: ROM/RAM models, expected-write scoreboard and
// latency / status checks for copy, verify, wrap, abort and reset cases.
module tb_rom_ram_copy_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       verify_en = 1'b0;
   logic [7:0] base_addr = '0;
   logic [7:0] length = '0;
   logic [3:0] rom_data = '0;
   logic [3:0] ram_q = '0;
   logic [7:0] addr;
   logic       we;
   logic       busy;
   logic       done;
   logic [7:0] mismatch_cnt;
   logic       aborted;

   logic [3:0] rom [256];
   logic [3:0] ram [256];
   logic       corrupt_en = 1'b0;
   logic [7:0] corrupt_a = '0;

   typedef struct packed {
      logic [7:0] a;
      logic [3:0] d;
   } wr_t;
   wr_t exp_q[$];

   int n_err = 0;
   int n_chk = 0;
   int done_cnt = 0;
   logic prev_we = 1'b0;

   always #5 clk = ~clk;

   rom_ram_copy_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .verify_en    (verify_en),
      .base_addr    (base_addr),
      .length       (length),
      .rom_data     (rom_data),
      .ram_q        (ram_q),
      .addr         (addr),
      .we           (we),
      .busy         (busy),
      .done         (done),
      .mismatch_cnt (mismatch_cnt),
      .aborted      (aborted)
   );

   always @(posedge clk) begin
      rom_data <= rom[addr];
      if (we) ram[addr] <= (corrupt_en && addr == corrupt_a) ? ~rom_data : rom_data;
      ram_q <= ram[addr];
   end

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Write monitor: every we pulse must match the next expected write.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (we) begin
         check_eq("we_single_cycle", 32'(prev_we), 0);
         if (exp_q.size() == 0) begin
            check_eq("we_unexpected", 32'(we), 0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_eq("wr_addr", 32'(addr), 32'(e.a));
            check_eq("wr_data", 32'(rom_data), 32'(e.d));
         end
      end
      prev_we = we;
   end

   task automatic start_job(input logic [7:0] b, input logic [7:0] l, input logic v);
      @(negedge clk);
      base_addr = b;
      length    = l;
      verify_en = v;
      start     = 1'b1;
      for (int i = 0; i < int'(l); i++) begin
         wr_t e;
         e.a = b + 8'(i);
         e.d = rom[e.a];
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int exp_lat, input int exp_mm, input bit poke);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (poke && n == 2) begin
            start     = 1'b1;
            length    = 8'd7;
            base_addr = 8'h50;
         end else if (poke && n == 3) begin
            start = 1'b0;
         end
      end while (!done && n < 300);
      check_eq("done_latency", 32'(n), 32'(exp_lat));
      check_eq("writes_left", 32'(exp_q.size()), 0);
      check_eq("mismatch_at_done", 32'(mismatch_cnt), 32'(exp_mm));
      exp_q.delete();
      @(negedge clk);
      check_eq("done_pulse_len", 32'(done), 0);
      check_eq("idle_after_done", 32'(busy), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int d0;
      for (int i = 0; i < 256; i++) begin
         rom[i] = 4'($urandom_range(0, 15));
         ram[i] = 4'($urandom_range(0, 15));
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_addr", 32'(addr), 0);
      check_eq("rst_we", 32'(we), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_mismatch", 32'(mismatch_cnt), 0);
      check_eq("rst_aborted", 32'(aborted), 0);
      rst_n = 1'b1;

      // Copy only; a start pulse mid-job must be ignored.
      start_job(8'h10, 8'd3, 1'b0);
      wait_done(7, 0, 1'b1);
      for (int i = 'h10; i <= 'h12; i++) check_eq("ram_copy", 32'(ram[i]), 32'(rom[i]));

      start_job(8'h20, 8'd4, 1'b1);
      wait_done(17, 0, 1'b0);

      corrupt_en = 1'b1;
      corrupt_a  = 8'h22;
      start_job(8'h20, 8'd4, 1'b1);
      wait_done(17, 1, 1'b0);
      corrupt_en = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("mismatch_hold", 32'(mismatch_cnt), 1);

      start_job(8'hFF, 8'd2, 1'b0);
      wait_done(5, 0, 1'b0);
      check_eq("ram_wrap_ff", 32'(ram[255]), 32'(rom[255]));
      check_eq("ram_wrap_00", 32'(ram[0]), 32'(rom[0]));

      start_job(8'h40, 8'd0, 1'b0);
      wait_done(1, 0, 1'b0);

      // Abort during the second WR of a 5-word job.
      d0 = done_cnt;
      start_job(8'h30, 8'd5, 1'b0);
      for (int n = 1; n <= 4; n++) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_we", 32'(we), 0);
      check_eq("abort_sticky", 32'(aborted), 1);
      check_eq("abort_writes_left", 32'(exp_q.size()), 3);
      exp_q.delete();
      repeat (5) @(negedge clk);
      check_eq("abort_no_done", 32'(done_cnt), 32'(d0));
      check_eq("aborted_holds", 32'(aborted), 1);

      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check_eq("abort_wins_busy", 32'(busy), 0);
      check_eq("abort_wins_aborted", 32'(aborted), 1);

      start_job(8'h30, 8'd5, 1'b0);
      check_eq("start_clears_aborted", 32'(aborted), 0);
      wait_done(11, 0, 1'b0);

      // Reset during the second VCMP of a verified 2-word job.
      d0 = done_cnt;
      corrupt_en = 1'b1;
      corrupt_a  = 8'h60;
      start_job(8'h60, 8'd2, 1'b1);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 7) check_eq("mm_before_reset", 32'(mismatch_cnt), 1);
      end
      rst_n = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_addr", 32'(addr), 0);
      check_eq("mid_rst_we", 32'(we), 0);
      check_eq("mid_rst_busy", 32'(busy), 0);
      check_eq("mid_rst_done", 32'(done), 0);
      check_eq("mid_rst_mismatch", 32'(mismatch_cnt), 0);
      check_eq("mid_rst_aborted", 32'(aborted), 0);
      rst_n = 1'b1;
      corrupt_en = 1'b0;
      exp_q.delete();
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check_eq("no_pending_job", 32'(busy), 0);
      end
      check_eq("rst_no_done", 32'(done_cnt), 32'(d0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
